// File: rtl/b13_rx_pkg.sv
// -----------------------------------------------------------------------------
// b13_rx_pkg
// Shared definitions for the b13 serial receiver: FSM state encoding, frame
// length and the bit-period derivation from the transmitter delay constant.
// -----------------------------------------------------------------------------
package b13_rx_pkg;

   // Data bits per frame (MSB first on the line).
   localparam int FRAME_BITS = 8;

   // Receiver FSM states.
   typedef enum logic [1:0] {
      RX_IDLE  = 2'b00,
      RX_DATA  = 2'b01,
      RX_STOP  = 2'b10,
      RX_ABORT = 2'b11
   } rx_state_t;

   // The transmitter spends DELAY_TIME cycles waiting plus two cycles of
   // handshake overhead between consecutive bit slots.
   function automatic int bit_period(input int delay_time);
      return delay_time + 2;
   endfunction

endpackage

// File: rtl/b13_serial_rx_if.sv
// -----------------------------------------------------------------------------
// b13_serial_rx_if
// Holding-register handshake between the receiver and its consumer.
//   rx_data    : received byte
//   data_valid : rx_data holds an unread byte
//   dsr        : receiver ready to accept (inverse of data_valid)
//   data_ack   : consumer accepts rx_data
// master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface b13_serial_rx_if;
   import b13_rx_pkg::*;

   logic [FRAME_BITS-1:0] rx_data;
   logic                  data_valid;
   logic                  dsr;
   logic                  data_ack;

   modport master (output rx_data, data_valid, dsr, input data_ack);
   modport slave  (input rx_data, data_valid, dsr, output data_ack);

endinterface

// File: rtl/b13_rx_bit_timer.sv
// -----------------------------------------------------------------------------
// b13_rx_bit_timer
// Free-running bit-slot timer. Counts 0..BIT_PERIOD-1 while enabled and wraps;
// the slot pulse marks the last count of each period.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   clear        : force timer to 0 (wins over enable)
//   enable       : advance the timer
//   slot         : high in the cycle where timer == BIT_PERIOD-1 (and enabled)
//   timer        : current count
// -----------------------------------------------------------------------------
module b13_rx_bit_timer #(
   parameter int BIT_PERIOD = 106,
   parameter int TIMER_W    = $clog2(BIT_PERIOD)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   output logic               slot,
   output logic [TIMER_W-1:0] timer
);

   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BIT_PERIOD - 1);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         timer <= '0;
      end else if (enable) begin
         timer <= (timer == TIMER_LAST) ? '0 : timer + 1'b1;
      end
   end

   assign slot = enable && (timer == TIMER_LAST);

endmodule

// File: rtl/b13_serial_rx.sv
// -----------------------------------------------------------------------------
// b13_serial_rx
// Receive end of the b13 serial link. A single low cycle on rx_in starts a
// frame; eight data bits (MSB first) follow, one per bit slot, then a stop
// slot that must be high. rx_in is only meaningful in slot cycles; any low
// level outside a slot is a framing error and the rest of the frame is
// skipped. Good bytes land in a valid/ack holding register.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   rx_in        : serial line, idle high (same clock domain as transmitter)
//   err_clr      : clears both sticky error flags
//   rx_bus       : holding-register handshake (rx_data/data_valid/dsr/data_ack)
//   busy         : frame in progress
//   frame_err    : sticky framing error
//   overrun_err  : sticky overrun (good frame arrived while byte unread)
// -----------------------------------------------------------------------------
module b13_serial_rx
   import b13_rx_pkg::*;
#(
   parameter int DELAY_TIME = 104
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   rx_in,
   input  logic                   err_clr,
   b13_serial_rx_if.master        rx_bus,
   output logic                   busy,
   output logic                   frame_err,
   output logic                   overrun_err
);

   localparam int BIT_PERIOD = bit_period(DELAY_TIME);
   localparam int TIMER_W    = $clog2(BIT_PERIOD);
   localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 1);

   rx_state_t             state;
   logic [2:0]            bit_idx;
   logic                  stop_next;   // in ABORT: the next slot is the stop slot
   logic [FRAME_BITS-1:0] shift_reg;
   logic [FRAME_BITS-1:0] rx_data_q;
   logic                  data_valid_q;
   logic                  slot;
   logic [TIMER_W-1:0]    timer;

   // Timer idles at 0 so the first data slot lands BIT_PERIOD cycles after
   // the start cycle.
   b13_rx_bit_timer #(
      .BIT_PERIOD (BIT_PERIOD),
      .TIMER_W    (TIMER_W)
   ) u_bit_timer (
      .clock  (clock),
      .reset  (reset),
      .clear  (state == RX_IDLE),
      .enable (state != RX_IDLE),
      .slot   (slot),
      .timer  (timer)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= RX_IDLE;
         bit_idx      <= '0;
         stop_next    <= 1'b0;
         shift_reg    <= '0;
         rx_data_q    <= '0;
         data_valid_q <= 1'b0;
         frame_err    <= 1'b0;
         overrun_err  <= 1'b0;
      end else begin
         // NOTE: defaults first, events below; the later non-blocking
         // assignment wins, so a new error beats err_clr and a delivery
         // beats the ack-driven clear in the same cycle.
         if (rx_bus.data_ack) data_valid_q <= 1'b0;
         if (err_clr) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
         end

         case (state)
            RX_IDLE: begin
               if (!rx_in) begin
                  state   <= RX_DATA;
                  bit_idx <= '0;
               end
            end

            RX_DATA: begin
               if (slot) begin
                  shift_reg <= {shift_reg[FRAME_BITS-2:0], rx_in};
                  if (bit_idx == LAST_BIT) state   <= RX_STOP;
                  else                     bit_idx <= bit_idx + 3'd1;
               end else if (!rx_in) begin
                  frame_err <= 1'b1;
                  stop_next <= 1'b0;
                  state     <= RX_ABORT;
               end
            end

            RX_STOP: begin
               if (slot) begin
                  state <= RX_IDLE;
                  if (!rx_in) begin
                     frame_err <= 1'b1;
                  end else if (data_valid_q && !rx_bus.data_ack) begin
                     overrun_err <= 1'b1;      // old byte kept
                  end else begin
                     rx_data_q    <= shift_reg;
                     data_valid_q <= 1'b1;
                  end
               end else if (!rx_in) begin
                  frame_err <= 1'b1;
                  stop_next <= 1'b1;
                  state     <= RX_ABORT;
               end
            end

            RX_ABORT: begin
               // Walk the remaining data slots so the frame ends on its
               // own stop slot; the line is ignored meanwhile.
               if (slot) begin
                  if (stop_next)                state     <= RX_IDLE;
                  else if (bit_idx == LAST_BIT) stop_next <= 1'b1;
                  else                          bit_idx   <= bit_idx + 3'd1;
               end
            end

            default: state <= RX_IDLE;
         endcase
      end
   end

   assign rx_bus.rx_data    = rx_data_q;
   assign rx_bus.data_valid = data_valid_q;
   assign rx_bus.dsr        = !data_valid_q;
   assign busy              = (state != RX_IDLE);

endmodule

// File: tb/tb_b13_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_b13_serial_rx
// Frames are generated from their byte value; an abstract receiver model
// (pending flag, last byte, error flags, queue of deliverable bytes) predicts
// the result. A monitor pops the queue on every accepted handshake.
// -----------------------------------------------------------------------------
module tb_b13_serial_rx;

   localparam int BP       = 106;        // DELAY_TIME + 2
   localparam int STOP_IDX = 9 * BP;     // stop slot offset from start

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic rx_in = 1'b1;
   logic err_clr = 1'b0;
   logic busy, frame_err, overrun_err;

   b13_serial_rx_if bus ();

   b13_serial_rx #(.DELAY_TIME(104)) dut (
      .clock       (clock),
      .reset       (reset),
      .rx_in       (rx_in),
      .err_clr     (err_clr),
      .rx_bus      (bus),
      .busy        (busy),
      .frame_err   (frame_err),
      .overrun_err (overrun_err)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [7:0] exp_q[$];
   bit         pending  = 1'b0;
   logic [7:0] exp_rx   = 8'h00;
   bit         exp_ferr = 1'b0;
   bit         exp_oerr = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rx_data"},     bus.rx_data,    0);
      check({tag, "_data_valid"},  bus.data_valid, 0);
      check({tag, "_dsr"},         bus.dsr,        1);
      check({tag, "_busy"},        busy,           0);
      check({tag, "_frame_err"},   frame_err,      0);
      check({tag, "_overrun_err"}, overrun_err,    0);
   endtask

   task automatic check_model(input string tag);
      check({tag, "_busy"},        busy,           0);
      check({tag, "_data_valid"},  bus.data_valid, pending);
      check({tag, "_dsr"},         bus.dsr,        !pending);
      check({tag, "_rx_data"},     bus.rx_data,    exp_rx);
      check({tag, "_frame_err"},   frame_err,      exp_ferr);
      check({tag, "_overrun_err"}, overrun_err,    exp_oerr);
   endtask

   // Drives one frame starting at the next edge. Offsets are edges counted
   // from the start edge (0). Negative offsets disable the option.
   task automatic send_frame(input logic [7:0] b, input int stray_at, input bit bad_stop,
                             input int ack_at, input int clr_at, input int reset_at);
      bit   killed = 1'b0;
      logic v;
      for (int i = 0; i <= STOP_IDX; i++) begin
         if (killed)             v = 1'b1;
         else if (i == 0)        v = 1'b0;
         else if (i == stray_at) v = 1'b0;
         else if (i == STOP_IDX) v = !bad_stop;
         else if (i % BP == 0)   v = b[8 - i / BP];
         else                    v = 1'b1;
         rx_in        = v;
         bus.data_ack = (i == ack_at);
         err_clr      = (i == clr_at);
         reset        = (i == reset_at);
         @(posedge clock);
         #1;
         if (i == 0) check("busy_after_start", busy, 1);
         if (i == stray_at && !killed) begin
            check("stray_frame_err", frame_err, 1);
            check("stray_busy", busy, 1);
         end
         if (i == STOP_IDX - 1 && !killed) check("busy_before_stop", busy, 1);
         if (i == reset_at) begin
            check_reset_values("reset_mid");
            killed = 1'b1;
         end
      end
      rx_in        = 1'b1;
      bus.data_ack = 1'b0;
      err_clr      = 1'b0;
      reset        = 1'b0;
   endtask

   // Updates the model from the frame's rules, sends it, checks the result.
   task automatic run_frame(input string tag, input logic [7:0] b, input int stray_at = -1,
                            input bit bad_stop = 1'b0, input int ack_at = -1,
                            input int clr_at = -1, input int reset_at = -1);
      if (clr_at >= 0) begin
         exp_ferr = 1'b0;
         exp_oerr = 1'b0;
      end
      if (ack_at >= 0 && pending) pending = 1'b0;
      if (reset_at >= 0) begin
         if (pending) void'(exp_q.pop_back());
         pending  = 1'b0;
         exp_rx   = 8'h00;
         exp_ferr = 1'b0;
         exp_oerr = 1'b0;
      end else if (stray_at >= 0 || bad_stop) begin
         exp_ferr = 1'b1;
      end else if (pending) begin
         exp_oerr = 1'b1;
      end else begin
         exp_q.push_back(b);
         exp_rx  = b;
         pending = 1'b1;
      end
      send_frame(b, stray_at, bad_stop, ack_at, clr_at, reset_at);
      check_model(tag);
   endtask

   task automatic ack_byte();
      bus.data_ack = 1'b1;
      @(posedge clock);
      #1;
      bus.data_ack = 1'b0;
      pending = 1'b0;
      check("ack_data_valid", bus.data_valid, 0);
      check("ack_dsr", bus.dsr, 1);
   endtask

   task automatic clear_errors();
      err_clr = 1'b1;
      @(posedge clock);
      #1;
      err_clr  = 1'b0;
      exp_ferr = 1'b0;
      exp_oerr = 1'b0;
      check("clr_frame_err", frame_err, 0);
      check("clr_overrun_err", overrun_err, 0);
   endtask

   // Monitor: every accepted handshake must deliver the oldest expected byte.
   initial begin
      forever begin
         @(negedge clock);
         if (!reset && bus.data_valid && bus.data_ack) begin
            check("mon_byte_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("mon_byte", bus.rx_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.data_ack = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check_reset_values("reset");
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Basic frames.
      run_frame("a5", 8'hA5);
      ack_byte();
      run_frame("ff", 8'hFF);
      ack_byte();

      // Stray low mid-frame (with err_clr in the same cycle), then recovery.
      run_frame("stray", 8'h00, 50, 1'b0, -1, 50);
      clear_errors();
      run_frame("3c", 8'h3C);
      ack_byte();

      // Overrun, then simultaneous completion and ack.
      run_frame("ovr_first", 8'h12);
      run_frame("ovr_second", 8'h34);
      ack_byte();
      clear_errors();
      run_frame("sim_first", 8'h12);
      run_frame("sim_second", 8'h34, -1, 1'b0, STOP_IDX);

      // Bad stop slot keeps the pending byte.
      run_frame("bad_stop", 8'h77, -1, 1'b1);
      clear_errors();
      run_frame("ovr_again", 8'h88);
      run_frame("bad_stop2", 8'h66, -1, 1'b1);

      // Reset mid-frame drops everything.
      run_frame("reset_frame", 8'h99, -1, 1'b0, -1, -1, 400);
      run_frame("after_reset", 8'hC3);
      ack_byte();

      // Randomized frames, ack at a random point of the next frame.
      for (int n = 0; n < 24; n++) begin
         logic [7:0] b;
         int         stray;
         bit         bad;
         int         ack;
         b     = 8'($urandom);
         stray = -1;
         if ($urandom_range(0, 5) == 0) begin
            do stray = int'($urandom_range(1, STOP_IDX - 1)); while (stray % BP == 0);
         end
         bad = ($urandom_range(0, 7) == 0);
         ack = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, STOP_IDX));
         run_frame("rand", b, stray, bad, ack);
         if (exp_ferr || exp_oerr) clear_errors();
      end
      if (pending) ack_byte();

      @(posedge clock);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
